instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 116 +++++++++++
 tb/tb_instr_fetch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// instr_fetch : single-outstanding instruction fetch with PC sequencing
// Revision 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        commit,
    input  logic [1:0]  next_sel,
    input  logic        taken,
    input  logic [31:0] jr_target,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_VALID = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [1:0] c_SEL_SEQ    = 2'b00;
    localparam logic [1:0] c_SEL_JUMP   = 2'b01;
    localparam logic [1:0] c_SEL_BRANCH = 2'b10;
    localparam logic [1:0] c_SEL_JR     = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        fault_q, fault_d;

    logic [31:0] w_pc4;
    logic [31:0] w_br_off;
    logic [31:0] w_next_pc;
    logic        w_jr_misaligned;

    assign w_pc4    = pc_q + 32'd4;
    assign w_br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign w_jr_misaligned = (next_sel == c_SEL_JR) && (jr_target[1:0] != 2'b00);

    always_comb begin
        w_next_pc = w_pc4;
        case (next_sel)
            c_SEL_SEQ:    w_next_pc = w_pc4;
            c_SEL_JUMP:   w_next_pc = {w_pc4[31:28], instr_q[25:0], 2'b00};
            c_SEL_BRANCH: w_next_pc = taken ? (w_pc4 + w_br_off) : w_pc4;
            c_SEL_JR:     w_next_pc = jr_target;
            default:      w_next_pc = w_pc4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        fault_d = fault_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                // A misaligned register target parks the core with pc left at the offender
                if (commit) begin
                    if (w_jr_misaligned) begin
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end else begin
                        pc_d    = w_next_pc;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == ST_VALID);
    assign fault       = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch : directed and random checks of instr_fetch against a model
// Revision 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        commit;
    logic [1:0]  next_sel;
    logic        taken;
    logic [31:0] jr_target;
    logic        fault;

    int n_assert;
    int n_fail;

    // model: mode 0 = waiting for memory, 1 = holding instruction, 2 = faulted
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .instr      (instr),
        .instr_valid(instr_valid),
        .commit     (commit),
        .next_sel   (next_sel),
        .taken      (taken),
        .jr_target  (jr_target),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_next_pc(input logic [31:0] cur_pc, input logic [31:0] ins,
                                                  input logic [1:0] sel, input logic tk,
                                                  input logic [31:0] jr);
        logic [31:0] seq;
        int          imm;
        seq = cur_pc + 32'd4;
        imm = int'($signed(ins[15:0]));
        case (sel)
            2'd0:    return seq;
            2'd1:    return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
            2'd2:    return tk ? (seq + 32'(imm * 4)) : seq;
            default: return jr;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":imem_req"},    {31'd0, imem_req},    {31'd0, m_mode == 0});
        chk({tag, ":imem_addr"},   imem_addr,            m_pc);
        chk({tag, ":pc"},          pc,                   m_pc);
        chk({tag, ":instr"},       instr,                m_instr);
        chk({tag, ":instr_valid"}, {31'd0, instr_valid}, {31'd0, m_mode == 1});
        chk({tag, ":fault"},       {31'd0, fault},       {31'd0, m_mode == 2});
    endtask

    // Advance one edge: model consumes the inputs currently applied
    task automatic tick(input string tag);
        int          nmode;
        logic [31:0] npc, ninstr;
        nmode = m_mode; npc = m_pc; ninstr = m_instr;
        if (reset) begin
            nmode = 0; npc = RESET_PC; ninstr = 32'd0;
        end else if (m_mode == 0 && imem_ack) begin
            ninstr = imem_rdata; nmode = 1;
        end else if (m_mode == 1 && commit) begin
            if (next_sel == 2'd3 && jr_target[1:0] != 2'd0) nmode = 2;
            else begin
                npc   = model_next_pc(m_pc, m_instr, next_sel, taken, jr_target);
                nmode = 0;
            end
        end
        @(posedge clk);
        #1;
        m_mode = nmode; m_pc = npc; m_instr = ninstr;
        check_all(tag);
    endtask

    task automatic do_fetch(input logic [31:0] data);
        imem_ack = 1'b1; imem_rdata = data;
        tick("fetch");
        imem_ack = 1'b0; imem_rdata = $urandom;
    endtask

    task automatic do_commit(input logic [1:0] sel, input logic tk, input logic [31:0] jr);
        commit = 1'b1; next_sel = sel; taken = tk; jr_target = jr;
        tick("commit");
        commit = 1'b0; next_sel = 2'($urandom); taken = 1'($urandom); jr_target = $urandom;
    endtask

    task automatic set_pc(input logic [31:0] target);
        do_fetch(32'h0000_0000);
        do_commit(2'd3, 1'b0, target);
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        m_mode = 0; m_pc = RESET_PC; m_instr = 32'd0;
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0;
        commit = 1'b0; next_sel = 2'd0; taken = 1'b0; jr_target = 32'd0;

        tick("reset");
        tick("reset2");
        reset = 1'b0;
        chk("post_reset_req", {31'd0, imem_req}, 32'd1);

        // first-cycle ack, then sequential commit
        do_fetch(32'h2008_0005);
        chk("r34_instr", instr, 32'h2008_0005);
        chk("r34_pc", pc, 32'h0000_0000);
        do_commit(2'd0, 1'b0, 32'd0);
        chk("r34_pc4", pc, 32'h0000_0004);
        chk("r34_req", {31'd0, imem_req}, 32'd1);

        // stalled memory, stray commit ignored
        for (int i = 0; i < 5; i++) begin
            commit = (i == 2);
            tick("stall");
        end
        commit = 1'b0;
        chk("stall_pc", pc, 32'h0000_0004);

        // branch taken with imm -1, then not taken
        set_pc(32'h0000_0010);
        do_fetch(32'h1000_FFFF);
        do_commit(2'd2, 1'b1, 32'hFFFF_FFFF);
        chk("br_taken", pc, 32'h0000_0010);
        do_fetch(32'h1000_FFFF);
        do_commit(2'd2, 1'b0, 32'hFFFF_FFFF);
        chk("br_not_taken", pc, 32'h0000_0014);

        // jump keeps upper nibble of pc4
        set_pc(32'hF000_0000);
        do_fetch(32'h0800_0040);
        do_commit(2'd1, 1'b1, 32'h0000_0003);
        chk("jump", pc, 32'hF000_0100);

        // sequential wrap
        set_pc(32'hFFFF_FFFC);
        do_fetch(32'h0000_0000);
        do_commit(2'd0, 1'b0, 32'd0);
        chk("wrap", pc, 32'h0000_0000);

        // misaligned jr faults, stays faulted under ack/commit
        set_pc(32'h0000_0040);
        do_fetch(32'h03E0_0008);
        do_commit(2'd3, 1'b0, 32'h0000_0102);
        chk("fault_flag", {31'd0, fault}, 32'd1);
        chk("fault_pc", pc, 32'h0000_0040);
        imem_ack = 1'b1; commit = 1'b1;
        for (int i = 0; i < 4; i++) tick("fault_hold");
        imem_ack = 1'b0; commit = 1'b0;
        chk("fault_req", {31'd0, imem_req}, 32'd0);
        reset = 1'b1;
        tick("fault_reset");
        reset = 1'b0;
        chk("fault_cleared", {31'd0, fault}, 32'd0);

        // reset while a request is pending discards a coincident ack
        set_pc(32'h0000_0200);
        tick("wait1");
        tick("wait2");
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick("rst_ack");
        reset = 1'b0; imem_ack = 1'b0;
        chk("rst_ack_pc", pc, RESET_PC);
        chk("rst_ack_instr", instr, 32'd0);
        tick("after_rst");

        // random traffic
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 59) == 0) || (m_mode == 2 && $urandom_range(0, 7) == 0);
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            commit     = 1'($urandom);
            next_sel   = 2'($urandom);
            taken      = 1'($urandom);
            jr_target  = $urandom;
            if ($urandom_range(0, 3) != 0) jr_target[1:0] = 2'b00;
            tick("rand");
        end
        reset = 1'b0; imem_ack = 1'b0; commit = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
